nml_mux_pipe: RTL and testbench
===============================

// Module: nml_mux_pipe
// PURPOSE
//  Parametrised N:1 x WIDTH nano-magnetic-logic multiplexer model on a four-phase zone clock.
//  Builds a binary mux tree from majority gates. Each 2:1 cell is AND=M(a,b,0) followed by OR=M(x,y,1).
//  Each tree level occupies two clock zones, framed by an input (orange) zone and an output (red) zone.
//  Sits between NML input drivers and downstream NML gate models.
//  Streams one operand set every 4 cycles, with valid tracking and per-zone mode visibility.
// PARAMETERS
//  N_IN   2  number of data inputs, >=2
//  WIDTH  1  bits per input
//  SEL_W  $clog2(N_IN)  select width (derived localparam)
//  LEVELS $clog2(N_IN)  mux tree depth (derived localparam)
//  Z      2*LEVELS+2  zone count: zone 0 input, zones 1..Z-2 majority, Z-1 output (derived)
// PORTS
//  clk        in   1            single clock; every zone advances on posedge
//  rst_n      in   1            asynchronous active-low reset
//  in_data    in   N_IN*WIDTH   input i at bits [i*WIDTH +: WIDTH]
//  sel        in   SEL_W        input select
//  in_valid   in   1            offer operand set; taken only when in_ready=1
//  in_ready   out  1            1 iff phase==0 (input zone switches on this edge)
//  out_data   out  WIDTH        output zone value; 0 while the zone is in reset
//  out_valid  out  1            one-cycle pulse on the cycle the output zone holds new valid data
//  phase      out  2            zone-clock phase counter
//  zone_mode  out  2*Z          per-zone mode this cycle: 00 RESET, 01 SWITCH, 10 HOLD
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - phase=0; every zone data and valid bit = 0.
//    - out_data=0, out_valid=0; in_ready=1 once released.
//  - Phase counter: phase <= phase+1 mod 4 each edge.
//  - On an edge with current phase p, zone z:
//    - SWITCH if z%4==p: loads from zone z-1, or from the inputs for z=0.
//    - RESET if (z+3)%4==p: data=0, valid=0.
//    - HOLD otherwise.
//    - zone_mode is decoded combinationally from phase using the same rule.
//  - Zone 0 switch: captures in_data, sel and valid=in_valid. With in_valid=0, captures data 0, valid 0.
//    in_valid in any other phase is ignored (no error, no capture).
//  - Majority zones:
//    - Zone 2l+1 (AND): M(sel_bit,hi,0) and M(~sel_bit,lo,0) for each pair at level l.
//    - Zone 2l+2 (OR): M(and_hi,and_lo,1). sel_bit = captured sel bit l, LSB first.
//    - sel and valid are carried alongside data through every zone.
//  - Input padding: inputs with index >= N_IN (tree padding) are constant 0. sel >= N_IN yields out_data=0 with valid kept.
//  - Latency: capture edge k -> output zone loads at edge k+Z-1. out_valid is high for the cycle after that edge only.
//    out_data is visible 3 cycles, then RESET to 0.
//  - Throughput: one operand set per 4 cycles. Overlapping sets never collide because zone z reloads exactly 4 edges apart.
//  - Reset mid-flight: all in-flight sets are discarded and never produce out_valid. Phase restarts at 0.
//  - All arithmetic is bitwise. No widths are extended. WIDTH bits are processed identically and independently.
// STRUCTURE
//  - Shared package nml_pkg:
//    - phase localparams PH0..PH3
//    - zone-mode codes MODE_RESET/SWITCH/HOLD
//    - function maj3(a,b,c)
//    - function zone_mode_of(z,phase)
//  - Sub-module nml_zone #(W):
//    - one zone register with switch/hold/reset control, async rst_n
//    - instantiated Z times via generate; the top holds the phase counter and the majority wiring
// TESTING
//  1. N_IN=2,W=1: in_data=2'b10, sel=1, in_valid at phase 0 -> out_valid 3 edges later, out_data=1; sel=0 -> out_data=0.
//  2. N_IN=2,W=1: all 8 (in1,in2,sel) combos -> out equals sel?in2:in1. out_data returns to 0 in the 4th cycle after load.
//  3. N_IN=4,W=8: in_data={D4,C3,B2,A1}, sel=2 -> out_data=8'hC3 after 5 edges.
//     Back-to-back sets every 4 cycles with sel=0,1,3 -> A1,B2,D4 in order.
//  4. in_valid=1 only at phases 1-3 -> no capture, out_valid never asserts. zone_mode matches the rule every cycle.
//  5. rst_n low for 1 cycle between capture and output -> immediate zero outputs, phase=0, no out_valid for dropped set.
//  6. N_IN=3,W=4: sel=3 -> out_data=0 with out_valid=1; sel=2 -> input 2 value.

Source files
------------

// File: rtl/nml_pkg.sv
// Shared definitions for the NML zone-clocked mux pipeline:
// phase codes, zone modes and the majority primitive.
package nml_pkg;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    typedef enum logic [1:0] {
        MODE_RESET  = 2'b00,
        MODE_SWITCH = 2'b01,
        MODE_HOLD   = 2'b10
    } zmode_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // A zone switches in its own phase and is wiped while its predecessor switches.
    function automatic zmode_t zone_mode_of(input int z, input logic [1:0] ph);
        logic [1:0] zp;
        zp = 2'(z);
        if (zp == ph)
            return MODE_SWITCH;
        if (zp + 2'd3 == ph)
            return MODE_RESET;
        return MODE_HOLD;
    endfunction

endpackage

// File: rtl/nml_mux_pipe_if.sv
// Operand/result bundle of the NML mux pipeline.
// master drives operands, slave is the pipeline.
interface nml_mux_pipe_if #(
    parameter int N_IN  = 2,
    parameter int WIDTH = 1
);
    localparam int SEL_W  = $clog2(N_IN);
    localparam int LEVELS = $clog2(N_IN);
    localparam int Z      = 2 * LEVELS + 2;

    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [1:0]            phase;
    logic [2*Z-1:0]        zone_mode;

    modport master (
        output in_data, sel, in_valid,
        input  in_ready, out_data, out_valid, phase, zone_mode
    );

    modport slave (
        input  in_data, sel, in_valid,
        output in_ready, out_data, out_valid, phase, zone_mode
    );

endinterface

// File: rtl/nml_zone.sv
// One NML clock zone: loads on SWITCH, clears on RESET,
// keeps its magnetisation on HOLD.
module nml_zone
    import nml_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  zmode_t       mode,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Zone register driven by the local zone-clock mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else begin
            unique case (mode)
                MODE_SWITCH: q <= d;
                MODE_RESET:  q <= '0;
                default:     q <= q;
            endcase
        end
    end

endmodule

// File: rtl/nml_mux_pipe.sv
// N:1 x WIDTH majority-gate mux tree on a four-phase zone clock.
// Every zone carries padded data, the select and a valid bit.
module nml_mux_pipe
    import nml_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int WIDTH = 1
) (
    input logic           clk,
    input logic           rst_n,
    nml_mux_pipe_if.slave bus
);

    localparam int SEL_W  = $clog2(N_IN);
    localparam int LEVELS = $clog2(N_IN);
    localparam int Z      = 2 * LEVELS + 2;
    localparam int NP     = 1 << LEVELS;
    localparam int DW     = NP * WIDTH;
    localparam int ZW     = DW + SEL_W + 1;
    localparam logic [1:0] PH_OUT = 2'(Z % 4);

    logic [1:0]            phase;
    logic [Z-1:0][ZW-1:0]  zd;
    logic [Z-1:0][ZW-1:0]  zq;
    logic [ZW-1:0]         in0;
    zmode_t                zm [Z];

    // Free-running zone-clock phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= PH0;
        else
            phase <= phase + 2'd1;
    end

    // Input zone source: operand set, or all-zero when nothing offered
    always_comb begin
        in0 = '0;
        if (bus.in_valid) begin
            in0[N_IN*WIDTH-1:0] = bus.in_data;
            in0[DW +: SEL_W]    = bus.sel;
            in0[ZW-1]           = 1'b1;
        end
    end

    assign zd[0] = in0;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int N = NP >> l;
        logic [ZW-1:0] src;
        logic [ZW-1:0] and_d;
        logic [ZW-1:0] and_q;
        logic [ZW-1:0] or_d;

        assign src   = zq[2*l];
        assign and_q = zq[2*l+1];

        // AND zone: gate each pair member with the select bit of this level
        always_comb begin
            and_d = '0;
            and_d[ZW-1:DW] = src[ZW-1:DW];
            for (int j = 0; j < N / 2; j++) begin
                for (int b = 0; b < WIDTH; b++) begin
                    and_d[(2*j+1)*WIDTH+b] =
                        maj3(src[DW+l], src[(2*j+1)*WIDTH+b], 1'b0);
                    and_d[2*j*WIDTH+b] =
                        maj3(~src[DW+l], src[2*j*WIDTH+b], 1'b0);
                end
            end
        end

        // OR zone: merge each gated pair into one entry of the next level
        always_comb begin
            or_d = '0;
            or_d[ZW-1:DW] = and_q[ZW-1:DW];
            for (int j = 0; j < N / 2; j++) begin
                for (int b = 0; b < WIDTH; b++) begin
                    or_d[j*WIDTH+b] =
                        maj3(and_q[(2*j+1)*WIDTH+b], and_q[2*j*WIDTH+b], 1'b1);
                end
            end
        end

        assign zd[2*l+1] = and_d;
        assign zd[2*l+2] = or_d;
    end

    assign zd[Z-1] = zq[Z-2];

    for (genvar z = 0; z < Z; z++) begin : g_zone
        assign zm[z] = zone_mode_of(z, phase);
        assign bus.zone_mode[2*z +: 2] = zm[z];

        nml_zone #(.W(ZW)) u_zone (
            .clk   (clk),
            .rst_n (rst_n),
            .mode  (zm[z]),
            .d     (zd[z]),
            .q     (zq[z])
        );
    end

    assign bus.phase     = phase;
    assign bus.in_ready  = (phase == PH0);
    assign bus.out_data  = zq[Z-1][WIDTH-1:0];
    assign bus.out_valid = zq[Z-1][ZW-1] & (phase == PH_OUT);

endmodule

// File: tb/tb_nml_mux_pipe.sv
// Scoreboard bench for nml_mux_pipe in three configurations:
// 2x1, 4x8 and 3x4 (padded tree).
module tb_nml_mux_pipe;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic [1:0] tph;

    exp_t sbq [3][$];
    int   hcnt [3];
    logic [7:0] hval [3];

    logic [7:0]  od [3];
    logic        ov [3];
    logic        rdy [3];
    logic [1:0]  ph [3];
    logic [15:0] zm [3];

    always #5 clk = ~clk;

    nml_mux_pipe_if #(.N_IN(2), .WIDTH(1)) ifa ();
    nml_mux_pipe_if #(.N_IN(4), .WIDTH(8)) ifb ();
    nml_mux_pipe_if #(.N_IN(3), .WIDTH(4)) ifc ();

    nml_mux_pipe #(.N_IN(2), .WIDTH(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    nml_mux_pipe #(.N_IN(4), .WIDTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    nml_mux_pipe #(.N_IN(3), .WIDTH(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    assign od[0] = 8'(ifa.out_data);
    assign od[1] = 8'(ifb.out_data);
    assign od[2] = 8'(ifc.out_data);
    assign ov[0] = ifa.out_valid;
    assign ov[1] = ifb.out_valid;
    assign ov[2] = ifc.out_valid;
    assign rdy[0] = ifa.in_ready;
    assign rdy[1] = ifb.in_ready;
    assign rdy[2] = ifc.in_ready;
    assign ph[0] = ifa.phase;
    assign ph[1] = ifb.phase;
    assign ph[2] = ifc.phase;
    assign zm[0] = 16'(ifa.zone_mode);
    assign zm[1] = 16'(ifb.zone_mode);
    assign zm[2] = 16'(ifc.zone_mode);

    // Reference phase and cycle count
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tph <= 2'd0;
        else        tph <= tph + 2'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int zc_of(input int k);
        return (k == 0) ? 4 : 6;
    endfunction

    function automatic logic [15:0] exp_zm(input int nz, input logic [1:0] p);
        logic [15:0] r;
        r = '0;
        for (int z = 0; z < nz; z++) begin
            if (z % 4 == int'(p))            r[2*z +: 2] = 2'b01;
            else if ((z + 3) % 4 == int'(p)) r[2*z +: 2] = 2'b00;
            else                             r[2*z +: 2] = 2'b10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: phase/ready/zone_mode each cycle, results vs scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) hcnt[k] = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("phase[%0d]", k), 16'(ph[k]), 16'(tph));
                chk($sformatf("in_ready[%0d]", k), 16'(rdy[k]),
                    16'(tph == 2'd0));
                chk($sformatf("zone_mode[%0d]", k), zm[k],
                    exp_zm(zc_of(k), tph));
                if (ov[k]) begin
                    if (sbq[k].size() == 0) begin
                        chk($sformatf("unexpected_valid[%0d]", k), 16'd1, 16'd0);
                        hcnt[k] = 0;
                    end else begin
                        exp_t e;
                        e = sbq[k].pop_front();
                        chk($sformatf("out_data[%0d]", k), 16'(od[k]), 16'(e.data));
                        chk($sformatf("latency[%0d]", k), 16'(cyc), 16'(e.due));
                        hval[k] = e.data;
                        hcnt[k] = 1;
                    end
                end else if (hcnt[k] > 0 && hcnt[k] < 3) begin
                    chk($sformatf("hold[%0d]", k), 16'(od[k]), 16'(hval[k]));
                    hcnt[k]++;
                end else if (hcnt[k] == 3) begin
                    chk($sformatf("cleared[%0d]", k), 16'(od[k]), 16'd0);
                    hcnt[k] = 0;
                end
            end
        end
    end

    // Offer one set at the next phase-0 edge; optionally expect its result
    task automatic send(input int k, input logic [31:0] data,
                        input logic [1:0] s, input logic [7:0] exp,
                        input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (tph != 2'd0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (tph != 2'd0)
            chk("send_wait", 16'(tph), 16'd0);
        case (k)
            0: begin ifa.in_data = data[1:0];  ifa.sel = s[0]; ifa.in_valid = 1'b1; end
            1: begin ifb.in_data = data;       ifb.sel = s;    ifb.in_valid = 1'b1; end
            default: begin ifc.in_data = data[11:0]; ifc.sel = s; ifc.in_valid = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        ifa.in_valid = 1'b0;
        ifb.in_valid = 1'b0;
        ifc.in_valid = 1'b0;
        if (push)
            sbq[k].push_back('{data: exp, due: cyc + zc_of(k) - 1});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 16'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 16'd0);
        repeat (4) @(negedge clk);
    endtask

    logic [1:0] va_d [8];
    logic       va_s [8];
    logic       va_e [8];

    initial begin
        va_d = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};
        va_s = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        va_e = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};

        ifa.in_data = '0; ifa.sel = '0; ifa.in_valid = 1'b0;
        ifb.in_data = '0; ifb.sel = '0; ifb.in_valid = 1'b0;
        ifc.in_data = '0; ifc.sel = '0; ifc.in_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_out_data_a", 16'(ifa.out_data), 16'd0);
        chk("rst_out_valid_a", 16'(ifa.out_valid), 16'd0);
        chk("rst_phase_b", 16'(ifb.phase), 16'd0);
        chk("rst_out_data_b", 16'(ifb.out_data), 16'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_a", 16'(ifa.in_ready), 16'd1);
        chk("rel_ready_c", 16'(ifc.in_ready), 16'd1);

        send(0, 32'h2, 2'd1, 8'h1, 1'b1);
        send(0, 32'h2, 2'd0, 8'h0, 1'b1);
        for (int i = 0; i < 8; i++)
            send(0, 32'(va_d[i]), 2'(va_s[i]), 8'(va_e[i]), 1'b1);
        drain();

        send(1, 32'hD4C3B2A1, 2'd2, 8'hC3, 1'b1);
        send(1, 32'hD4C3B2A1, 2'd0, 8'hA1, 1'b1);
        send(1, 32'hD4C3B2A1, 2'd1, 8'hB2, 1'b1);
        send(1, 32'hD4C3B2A1, 2'd3, 8'hD4, 1'b1);
        drain();

        send(2, 32'h95A, 2'd3, 8'h0, 1'b1);
        send(2, 32'h95A, 2'd2, 8'h9, 1'b1);
        send(2, 32'h95A, 2'd0, 8'hA, 1'b1);
        send(2, 32'h95A, 2'd1, 8'h5, 1'b1);
        drain();

        ifa.in_data = 2'b11;
        ifa.sel = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ifa.in_valid = (tph != 2'd0);
        end
        @(negedge clk);
        ifa.in_valid = 1'b0;
        repeat (8) @(negedge clk);

        send(0, 32'h2, 2'd1, 8'h1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_data", 16'(ifa.out_data), 16'd0);
        chk("midrst_out_valid", 16'(ifa.out_valid), 16'd0);
        chk("midrst_phase", 16'(ifa.phase), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        chk("leftover", 16'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
